// File: rtl/ball_motion.sv
`default_nettype none
//==============================================================================
// Module   : ball_motion
// Purpose  : Per-ball motion integrator. Holds the ball velocity and
//            fixed-point position, launches the ball on a cue strike, adopts
//            the friction-adjusted speed once per frame, advances the
//            position, and reflects velocity off the table cushions.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            frame_tick          - once-per-frame position-update strobe
//            cue_hit, cue_*speed - cue strike and signed launch velocity
//            *speed_fric, done_fric - friction stage speed and stopped flag
//            xspeed, yspeed      - current velocity registers
//            ball_x, ball_y      - integer pixel position
//            wall_hit, any_hit   - {left,right,top,bottom} contact pulses
//            moving, motion_state- status / debug
// Revision : 1.0 - initial release
//==============================================================================
module ball_motion #(
    parameter int FRAC_BITS = 4,
    parameter int X_MIN     = 16,
    parameter int X_MAX     = 992,
    parameter int Y_MIN     = 16,
    parameter int Y_MAX     = 736,
    parameter int X_INIT    = 300,
    parameter int Y_INIT    = 384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        cue_hit,
    input  logic [10:0] cue_xspeed,
    input  logic [10:0] cue_yspeed,
    input  logic [10:0] xspeed_fric,
    input  logic [10:0] yspeed_fric,
    input  logic        done_fric,
    output logic [10:0] xspeed,
    output logic [10:0] yspeed,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic [3:0]  wall_hit,
    output logic        any_hit,
    output logic        moving,
    output logic [1:0]  motion_state
);

    localparam int c_PW_X = 11 + FRAC_BITS;      // x position register width
    localparam int c_PW_Y = 10 + FRAC_BITS;      // y position register width
    localparam int c_NW   = 11 + FRAC_BITS + 2;  // signed candidate width

    localparam logic signed [c_NW-1:0] c_X_LO = c_NW'(X_MIN << FRAC_BITS);
    localparam logic signed [c_NW-1:0] c_X_HI = c_NW'(X_MAX << FRAC_BITS);
    localparam logic signed [c_NW-1:0] c_Y_LO = c_NW'(Y_MIN << FRAC_BITS);
    localparam logic signed [c_NW-1:0] c_Y_HI = c_NW'(Y_MAX << FRAC_BITS);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_MOVING = 2'd1;
    localparam logic [1:0] c_SETTLE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_PW_X-1:0] r_pos_x;
    logic [c_PW_Y-1:0] r_pos_y;
    logic [10:0]       r_xspeed;
    logic [10:0]       r_yspeed;
    logic [3:0]        r_wall_hit;
    logic              r_any_hit;

    logic signed [c_NW-1:0] w_nx;
    logic signed [c_NW-1:0] w_ny;
    logic [c_PW_X-1:0]      w_pos_x_nxt;
    logic [c_PW_Y-1:0]      w_pos_y_nxt;
    logic [10:0]            w_xspeed_nxt;
    logic [10:0]            w_yspeed_nxt;
    logic [3:0]             w_hit;

    // Two's-complement negate; -1024 has no positive counterpart in 11 bits,
    // so it saturates to +1023 instead of wrapping back to itself.
    function automatic logic [10:0] f_neg(input logic [10:0] v);
        f_neg = (v == 11'h400) ? 11'h3FF : (~v + 11'd1);
    endfunction

    // Candidate positions: position zero-extended, speed sign-extended, with
    // two guard bits so both underflow and overflow stay representable.
    assign w_nx = $signed({{(c_NW-c_PW_X){1'b0}}, r_pos_x})
                + $signed({{(c_NW-11){xspeed_fric[10]}}, xspeed_fric});
    assign w_ny = $signed({{(c_NW-c_PW_Y){1'b0}}, r_pos_y})
                + $signed({{(c_NW-11){yspeed_fric[10]}}, yspeed_fric});

    // Per-axis cushion resolution; the axes are independent so a corner
    // contact raises two hit bits at once.
    always_comb begin
        w_pos_x_nxt  = w_nx[c_PW_X-1:0];
        w_xspeed_nxt = xspeed_fric;
        w_pos_y_nxt  = w_ny[c_PW_Y-1:0];
        w_yspeed_nxt = yspeed_fric;
        w_hit        = 4'b0000;
        if (w_nx < c_X_LO) begin
            w_pos_x_nxt  = c_X_LO[c_PW_X-1:0];
            w_xspeed_nxt = f_neg(xspeed_fric);
            w_hit[3]     = 1'b1;
        end else if (w_nx > c_X_HI) begin
            w_pos_x_nxt  = c_X_HI[c_PW_X-1:0];
            w_xspeed_nxt = f_neg(xspeed_fric);
            w_hit[2]     = 1'b1;
        end
        if (w_ny < c_Y_LO) begin
            w_pos_y_nxt  = c_Y_LO[c_PW_Y-1:0];
            w_yspeed_nxt = f_neg(yspeed_fric);
            w_hit[1]     = 1'b1;
        end else if (w_ny > c_Y_HI) begin
            w_pos_y_nxt  = c_Y_HI[c_PW_Y-1:0];
            w_yspeed_nxt = f_neg(yspeed_fric);
            w_hit[0]     = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (cue_hit)    w_state_nxt = c_MOVING;
            c_MOVING: if (done_fric)  w_state_nxt = c_SETTLE;
            c_SETTLE: if (!done_fric) w_state_nxt = c_IDLE;
            default:                  w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath: velocity, position and contact pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_x    <= c_PW_X'(X_INIT << FRAC_BITS);
            r_pos_y    <= c_PW_Y'(Y_INIT << FRAC_BITS);
            r_xspeed   <= 11'd0;
            r_yspeed   <= 11'd0;
            r_wall_hit <= 4'b0000;
            r_any_hit  <= 1'b0;
        end else begin
            r_wall_hit <= 4'b0000;
            r_any_hit  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // A coincident frame_tick is ignored: launch only.
                    if (cue_hit) begin
                        r_xspeed <= cue_xspeed;
                        r_yspeed <= cue_yspeed;
                    end
                end
                c_MOVING: begin
                    // Stopping wins over a same-cycle frame update.
                    if (done_fric) begin
                        r_xspeed <= 11'd0;
                        r_yspeed <= 11'd0;
                    end else if (frame_tick) begin
                        r_pos_x    <= w_pos_x_nxt;
                        r_pos_y    <= w_pos_y_nxt;
                        r_xspeed   <= w_xspeed_nxt;
                        r_yspeed   <= w_yspeed_nxt;
                        r_wall_hit <= w_hit;
                        r_any_hit  <= |w_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign xspeed       = r_xspeed;
    assign yspeed       = r_yspeed;
    assign ball_x       = r_pos_x[FRAC_BITS+10:FRAC_BITS];
    assign ball_y       = r_pos_y[FRAC_BITS+9:FRAC_BITS];
    assign wall_hit     = r_wall_hit;
    assign any_hit      = r_any_hit;
    assign moving       = (r_state == c_MOVING);
    assign motion_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
//==============================================================================
// Module   : tb_ball_motion
// Purpose  : Self-checking bench for ball_motion. Directed scenarios followed
//            by randomized stimulus, every cycle compared against a
//            behavioural model of the ball written in plain integer units.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        cue_hit = 1'b0;
    logic [10:0] cue_xspeed = '0;
    logic [10:0] cue_yspeed = '0;
    logic [10:0] xspeed_fric = '0;
    logic [10:0] yspeed_fric = '0;
    logic        done_fric = 1'b0;
    logic [10:0] xspeed;
    logic [10:0] yspeed;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [3:0]  wall_hit;
    logic        any_hit;
    logic        moving;
    logic [1:0]  motion_state;

    ball_motion dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .cue_hit      (cue_hit),
        .cue_xspeed   (cue_xspeed),
        .cue_yspeed   (cue_yspeed),
        .xspeed_fric  (xspeed_fric),
        .yspeed_fric  (yspeed_fric),
        .done_fric    (done_fric),
        .xspeed       (xspeed),
        .yspeed       (yspeed),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .wall_hit     (wall_hit),
        .any_hit      (any_hit),
        .moving       (moving),
        .motion_state (motion_state)
    );

    always #5 clk = ~clk;

    // Reference model: position in 1/16-pixel units, speeds as plain ints.
    // Modes: 0 idle, 1 rolling, 2 waiting for friction stage to rearm.
    int m_mode;
    int m_px, m_py, m_vx, m_vy;
    int m_hit;
    int n_vec  = 0;
    int n_fail = 0;

    function automatic int reflect(input int v);
        return (v == -1024) ? 1023 : -v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".ball_x"}, int'(ball_x), m_px / 16);
        chk({tag, ".ball_y"}, int'(ball_y), m_py / 16);
        chk({tag, ".xspeed"}, int'($signed(xspeed)), m_vx);
        chk({tag, ".yspeed"}, int'($signed(yspeed)), m_vy);
        chk({tag, ".wall_hit"}, int'(wall_hit), m_hit);
        chk({tag, ".any_hit"}, int'(any_hit), (m_hit != 0) ? 1 : 0);
        chk({tag, ".moving"}, int'(moving), (m_mode == 1) ? 1 : 0);
        chk({tag, ".state"}, int'(motion_state), m_mode);
    endtask

    // One clock of stimulus: drive on the falling edge, advance the model at
    // the rising edge, compare 1 time unit later.
    task automatic step(input string tag, input logic rst, input logic ft,
                        input logic cue, input logic done,
                        input int cx, input int cy, input int fx, input int fy);
        int nx, ny;
        @(negedge clk);
        reset       = rst;
        frame_tick  = ft;
        cue_hit     = cue;
        done_fric   = done;
        cue_xspeed  = 11'(cx);
        cue_yspeed  = 11'(cy);
        xspeed_fric = 11'(fx);
        yspeed_fric = 11'(fy);
        @(posedge clk);
        m_hit = 0;
        if (rst) begin
            m_mode = 0;
            m_px = 300 * 16; m_py = 384 * 16;
            m_vx = 0; m_vy = 0;
        end else if (m_mode == 0) begin
            if (cue) begin
                m_vx = cx; m_vy = cy; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (done) begin
                m_vx = 0; m_vy = 0; m_mode = 2;
            end else if (ft) begin
                nx = m_px + fx;
                ny = m_py + fy;
                if (nx < 16 * 16)       begin m_px = 16 * 16;  m_vx = reflect(fx); m_hit += 8; end
                else if (nx > 992 * 16) begin m_px = 992 * 16; m_vx = reflect(fx); m_hit += 4; end
                else                    begin m_px = nx;       m_vx = fx; end
                if (ny < 16 * 16)       begin m_py = 16 * 16;  m_vy = reflect(fy); m_hit += 2; end
                else if (ny > 736 * 16) begin m_py = 736 * 16; m_vy = reflect(fy); m_hit += 1; end
                else                    begin m_py = ny;       m_vy = fy; end
            end
        end else begin
            if (!done) m_mode = 0;
        end
        #1;
        chk_model(tag);
    endtask

    // Rolls the ball to an exact pixel target using the friction inputs.
    task automatic move_to(input int tx, input int ty);
        int dx, dy;
        for (int k = 0; k < 60; k++) begin
            if (m_px == tx * 16 && m_py == ty * 16) break;
            dx = tx * 16 - m_px;
            dy = ty * 16 - m_py;
            if (dx > 1000) dx = 1000;
            if (dx < -1000) dx = -1000;
            if (dy > 1000) dy = 1000;
            if (dy < -1000) dy = -1000;
            step("move", 0, 1, 0, 0, 0, 0, dx, dy);
        end
        chk("move_x", int'(ball_x), tx);
        chk("move_y", int'(ball_y), ty);
    endtask

    initial begin
        int r;
        m_mode = 0; m_px = 0; m_py = 0; m_vx = 0; m_vy = 0; m_hit = 0;

        // Reset state
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_bx", int'(ball_x), 300);
        chk("rst_by", int'(ball_y), 384);
        chk("rst_state", int'(motion_state), 0);

        // Launch with a coincident frame_tick: ball must not move
        step("launch", 0, 1, 1, 0, 32, -16, 32, -16);
        chk("launch_vx", int'($signed(xspeed)), 32);
        chk("launch_bx", int'(ball_x), 300);
        chk("launch_by", int'(ball_y), 384);
        step("tick1", 0, 1, 0, 0, 0, 0, m_vx, m_vy);
        chk("tick1_bx", int'(ball_x), 302);
        chk("tick1_by", int'(ball_y), 383);
        for (int i = 0; i < 3; i++) begin
            step("idle_gap", 0, 0, 0, 0, 0, 0, m_vx, m_vy);
            step("tickn", 0, 1, 0, 0, 0, 0, m_vx, m_vy);
        end
        chk("tick4_bx", int'(ball_x), 308);
        chk("tick4_by", int'(ball_y), 380);

        // Left cushion from 20 px
        move_to(20, 380);
        step("left", 0, 1, 0, 0, 0, 0, -128, 0);
        chk("left_bx", int'(ball_x), 16);
        chk("left_vx", int'($signed(xspeed)), 128);
        chk("left_hit", int'(wall_hit), 4'b1000);
        chk("left_any", int'(any_hit), 1);
        step("left_after", 0, 0, 0, 0, 0, 0, m_vx, m_vy);
        chk("left_any_off", int'(any_hit), 0);

        // Corner contact, right + bottom
        move_to(990, 734);
        step("corner", 0, 1, 0, 0, 0, 0, 64, 64);
        chk("corner_bx", int'(ball_x), 992);
        chk("corner_by", int'(ball_y), 736);
        chk("corner_vx", int'($signed(xspeed)), -64);
        chk("corner_vy", int'($signed(yspeed)), -64);
        chk("corner_hit", int'(wall_hit), 4'b0101);

        // Stop wins over a coincident frame_tick
        step("stop", 0, 1, 0, 1, 0, 0, -200, -200);
        chk("stop_bx", int'(ball_x), 992);
        chk("stop_vx", int'($signed(xspeed)), 0);
        chk("stop_state", int'(motion_state), 2);
        step("settle_cue", 0, 0, 1, 1, 77, 77, 0, 0);
        chk("settle_hold", int'(motion_state), 2);
        step("rearm", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rearm_state", int'(motion_state), 0);
        step("relaunch", 0, 0, 1, 0, -10, 20, 0, 0);
        chk("relaunch_vx", int'($signed(xspeed)), -10);

        // cue ignored while rolling, then reset mid-roll
        step("cue_moving", 0, 0, 1, 0, 500, 500, 0, 0);
        chk("cue_moving_vx", int'($signed(xspeed)), -10);
        step("roll", 0, 1, 0, 0, 0, 0, -300, -300);
        step("mid_reset", 1, 1, 0, 0, 0, 0, 100, 100);
        chk("mid_reset_bx", int'(ball_x), 300);
        chk("mid_reset_by", int'(ball_y), 384);
        chk("mid_reset_state", int'(motion_state), 0);

        // Saturating reflection of -1024 on both axes
        step("sat_launch", 0, 0, 1, 0, 1, 1, 0, 0);
        move_to(20, 20);
        step("sat", 0, 1, 0, 0, 0, 0, -1024, -1024);
        chk("sat_vx", int'($signed(xspeed)), 1023);
        chk("sat_vy", int'($signed(yspeed)), 1023);
        chk("sat_hit", int'(wall_hit), 4'b1010);

        // Right wall with -1024: ordinary move, no reflection
        move_to(992, 400);
        step("right_neg", 0, 1, 0, 0, 0, 0, -1024, 0);
        chk("right_neg_vx", int'($signed(xspeed)), -1024);
        chk("right_neg_hit", int'(wall_hit), 0);

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            logic rst, ft, cue, done;
            int cx, cy, fx, fy;
            r    = int'($urandom_range(0, 999));
            rst  = (r < 3);
            ft   = ($urandom_range(0, 1) == 1);
            cue  = ($urandom_range(0, 9) == 0);
            done = ($urandom_range(0, 24) == 0) || (m_mode == 2 && $urandom_range(0, 1) == 1);
            cx   = int'($urandom_range(0, 2047)) - 1024;
            cy   = int'($urandom_range(0, 2047)) - 1024;
            if ($urandom_range(0, 3) == 0) begin
                fx = int'($urandom_range(0, 2047)) - 1024;
                fy = int'($urandom_range(0, 2047)) - 1024;
            end else begin
                fx = m_vx;
                fy = m_vy;
            end
            step("rand", rst, ft, cue, done, cx, cy, fx, fy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
